// File: rtl/div16s8_seq_pkg.sv
// Shared types and constants for the sequential signed divider.
package div16s8_seq_pkg;

    localparam int DW_N_DEF = 16;
    localparam int DW_D_DEF = 8;

    // Quotient saturation values for the divide-by-zero and overflow results
    localparam logic [DW_N_DEF-1:0] Q_SAT_POS = 16'h7FFF;
    localparam logic [DW_N_DEF-1:0] Q_SAT_NEG = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div16s8_seq_if.sv
// Operand and result handshake bundle for the sequential divider.
interface div16s8_seq_if
    import div16s8_seq_pkg::*;
#(
    parameter int DW_N = DW_N_DEF,
    parameter int DW_D = DW_D_DEF
);

    logic            in_valid;
    logic            in_ready;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            div_zero;
    logic            ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

endinterface

// File: rtl/div16s8_seq_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor magnitude.
module div_step
    import div16s8_seq_pkg::*;
#(
    parameter int DW_D = DW_D_DEF
) (
    input  logic [DW_D:0]   prem,
    input  logic            next_bit,
    input  logic [DW_D-1:0] dmag,
    output logic [DW_D:0]   prem_next,
    output logic            q_bit
);

    logic [DW_D+1:0] shifted;
    logic [DW_D:0]   diff;

    // The true difference is below dmag whenever it is kept, so truncation is safe
    assign shifted   = {prem, next_bit};
    assign diff      = shifted[DW_D:0] - {1'b0, dmag};
    assign q_bit     = (shifted >= {2'b00, dmag});
    assign prem_next = q_bit ? diff : shifted[DW_D:0];

endmodule

// File: rtl/div16s8_seq.sv
// Sequential signed divider, one quotient bit per clock on operand magnitudes,
// with optional skipping of low quotient bits.
module div16s8_seq
    import div16s8_seq_pkg::*;
#(
    parameter int DW_N       = DW_N_DEF,
    parameter int DW_D       = DW_D_DEF,
    parameter int APPROX_LSB = 0
) (
    input logic               clk,
    input logic               rst_n,
    div16s8_seq_if.slave      bus
);

    localparam int            K     = DW_N - APPROX_LSB;
    localparam int            CW    = $clog2(DW_N + 1);
    localparam logic [CW-1:0] K_CNT = CW'(K);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [DW_N-1:0] n_reg;
    logic [DW_D-1:0] d_reg;
    logic            neg_n;
    logic            neg_d;
    logic            special;
    logic [DW_N-1:0] n_sh;
    logic [DW_D-1:0] d_mag;
    logic [DW_D:0]   prem;
    logic [DW_N-1:0] q_sh;

    logic            in_ready_r;
    logic            out_valid_r;
    logic [DW_N-1:0] quotient_r;
    logic [DW_D-1:0] remainder_r;
    logic            div_zero_r;
    logic            ovf_r;

    logic [DW_D:0]   step_prem;
    logic            step_q;
    logic [DW_N-1:0] q_mag;
    logic [DW_D-1:0] rem_mag;

    div_step #(.DW_D(DW_D)) u_step (
        .prem      (prem),
        .next_bit  (n_sh[DW_N-1]),
        .dmag      (d_mag),
        .prem_next (step_prem),
        .q_bit     (step_q)
    );

    assign q_mag   = q_sh << APPROX_LSB;
    assign rem_mag = prem[DW_D-1:0];

    // Special results take the FIX slot too, so every result leaves through the same stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            n_reg       <= '0;
            d_reg       <= '0;
            neg_n       <= 1'b0;
            neg_d       <= 1'b0;
            special     <= 1'b0;
            n_sh        <= '0;
            d_mag       <= '0;
            prem        <= '0;
            q_sh        <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        n_reg      <= bus.dividend;
                        d_reg      <= bus.divisor;
                        div_zero_r <= 1'b0;
                        ovf_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                        state      <= PREP;
                    end
                end
                PREP: begin
                    neg_n   <= n_reg[DW_N-1];
                    neg_d   <= d_reg[DW_D-1];
                    n_sh    <= n_reg[DW_N-1] ? -n_reg : n_reg;
                    d_mag   <= d_reg[DW_D-1] ? -d_reg : d_reg;
                    prem    <= '0;
                    q_sh    <= '0;
                    cnt     <= K_CNT;
                    special <= 1'b0;
                    if (d_reg == '0) begin
                        special    <= 1'b1;
                        div_zero_r <= 1'b1;
                        q_sh       <= n_reg[DW_N-1] ? Q_SAT_NEG : Q_SAT_POS;
                        state      <= FIX;
                    end else if (n_reg == Q_SAT_NEG && d_reg == '1) begin
                        special <= 1'b1;
                        ovf_r   <= 1'b1;
                        q_sh    <= Q_SAT_POS;
                        state   <= FIX;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    prem <= step_prem;
                    n_sh <= n_sh << 1;
                    q_sh <= {q_sh[DW_N-2:0], step_q};
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (special) begin
                        quotient_r  <= q_sh;
                        remainder_r <= '0;
                    end else begin
                        quotient_r  <= (neg_n ^ neg_d) ? -q_mag : q_mag;
                        remainder_r <= (APPROX_LSB > 0) ? '0 : (neg_n ? -rem_mag : rem_mag);
                    end
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_div16s8_seq.sv
// Self-checking bench for div16s8_seq: an exact instance and an APPROX_LSB=4 instance
// checked against an integer-arithmetic reference model.
module tb_div16s8_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    div16s8_seq_if #(.DW_N(16), .DW_D(8)) bus_e ();
    div16s8_seq_if #(.DW_N(16), .DW_D(8)) bus_a ();

    div16s8_seq #(.DW_N(16), .DW_D(8), .APPROX_LSB(0)) dut_exact (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_e.slave)
    );

    div16s8_seq #(.DW_N(16), .DW_D(8), .APPROX_LSB(4)) dut_apx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    // Reference: plain signed integer division, or the floor-by-2^a approximation
    function automatic void model(input int a, input logic [15:0] n, input logic [7:0] d,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int ni, di, mag, qi;
        ni = $signed(n);
        di = $signed(d);
        dz = 1'b0;
        ov = 1'b0;
        r  = 8'h00;
        if (di == 0) begin
            dz = 1'b1;
            q  = (ni >= 0) ? 16'h7FFF : 16'h8000;
        end else if (ni == -32768 && di == -1) begin
            ov = 1'b1;
            q  = 16'h7FFF;
        end else if (a == 0) begin
            q = 16'(ni / di);
            r = 8'(ni % di);
        end else begin
            mag = ((ni < 0 ? -ni : ni) / ((di < 0 ? -di : di) << a)) << a;
            qi  = ((ni < 0) != (di < 0)) ? -mag : mag;
            q   = 16'(qi);
        end
    endfunction

    task automatic drive(input bit apx, input logic v, input logic [15:0] n, input logic [7:0] d);
        if (apx) begin
            bus_a.in_valid = v;
            bus_a.dividend = n;
            bus_a.divisor  = d;
        end else begin
            bus_e.in_valid = v;
            bus_e.dividend = n;
            bus_e.divisor  = d;
        end
    endtask

    task automatic set_out_ready(input bit apx, input logic v);
        if (apx) bus_a.out_ready = v;
        else     bus_e.out_ready = v;
    endtask

    function automatic logic rd_in_ready(input bit apx);
        return apx ? bus_a.in_ready : bus_e.in_ready;
    endfunction

    function automatic logic rd_out_valid(input bit apx);
        return apx ? bus_a.out_valid : bus_e.out_valid;
    endfunction

    // Runs one operation; lat = edges after the accept edge until out_valid is seen
    task automatic run_op(input bit apx, input logic [15:0] n, input logic [7:0] d, input bit hs,
                          output logic [15:0] q, output logic [7:0] r,
                          output logic dz, output logic ov, output int lat);
        int guard;
        guard = 0;
        while (!rd_in_ready(apx) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        drive(apx, 1'b1, n, d);
        @(posedge clk); #1;
        drive(apx, 1'b0, n, d);
        lat = 0;
        while (!rd_out_valid(apx) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rd_out_valid(apx)) begin
            n_fail++;
            $display("[TB] FAIL op_timeout: out_valid=0 after %0d edges, required 1", lat);
        end
        q  = apx ? bus_a.quotient  : bus_e.quotient;
        r  = apx ? bus_a.remainder : bus_e.remainder;
        dz = apx ? bus_a.div_zero  : bus_e.div_zero;
        ov = apx ? bus_a.ovf       : bus_e.ovf;
        if (hs) begin
            set_out_ready(apx, 1'b1);
            @(posedge clk); #1;
            set_out_ready(apx, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 16'h0, 8'h0);
        set_out_ready(0, 1'b0);
        set_out_ready(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_e.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus_e.in_ready); end
        n_checks++; if (bus_e.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus_e.out_valid); end
        n_checks++; if (bus_e.quotient !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_quotient: got %h want 0000", bus_e.quotient); end
        n_checks++; if (bus_e.remainder !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_remainder: got %h want 00", bus_e.remainder); end
        n_checks++; if ({bus_e.div_zero, bus_e.ovf} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 00", {bus_e.div_zero, bus_e.ovf}); end
        n_checks++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_apx_in_ready: got %b want 1", bus_a.in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [15:0] tn [10] = '{16'd100, 16'hFF9C, 16'd100, 16'hFF9C, 16'd5, 16'hFFFB, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
        logic [7:0]  td [10] = '{8'd7, 8'd7, 8'hF9, 8'hF9, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h80};
        logic [15:0] tq [10] = '{16'h000E, 16'hFFF2, 16'hFFF2, 16'h000E, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0100, 16'hFF01};
        logic [7:0]  tr [10] = '{8'h02, 8'hFE, 8'h02, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F};
        logic [1:0]  tf [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        int          tl [10] = '{18, 18, 18, 18, 2, 2, 2, 18, 18, 18};
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz, ov;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            run_op(0, tn[i], td[i], 1'b1, q, r, dz, ov, lat);
            n_checks++; if (q !== tq[i]) begin n_fail++; $display("[TB] FAIL vec%0d_quotient: got %h want %h", i, q, tq[i]); end
            n_checks++; if (r !== tr[i]) begin n_fail++; $display("[TB] FAIL vec%0d_remainder: got %h want %h", i, r, tr[i]); end
            n_checks++; if ({dz, ov} !== tf[i]) begin n_fail++; $display("[TB] FAIL vec%0d_flags: got %b want %b", i, {dz, ov}, tf[i]); end
            n_checks++; if (lat != tl[i]) begin n_fail++; $display("[TB] FAIL vec%0d_latency: got %0d want %0d", i, lat, tl[i]); end
        end
    endtask

    task automatic test_random_exact();
        logic [15:0] n, q, eq;
        logic [7:0]  d, r, er;
        logic        dz, ov, edz, eov;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            n = 16'($urandom);
            d = 8'($urandom);
            if (i % 10 == 3) d = 8'h00;
            if (i % 10 == 7) begin n = 16'h8000; d = 8'($urandom_range(0, 1) ? 8'hFF : 8'h80); end
            model(0, n, d, eq, er, edz, eov);
            run_op(0, n, d, 1'b1, q, r, dz, ov, lat);
            n_checks++; if (q !== eq || r !== er) begin n_fail++; $display("[TB] FAIL rand_exact %h/%h: got q=%h r=%h want q=%h r=%h", n, d, q, r, eq, er); end
            n_checks++; if ({dz, ov} !== {edz, eov}) begin n_fail++; $display("[TB] FAIL rand_exact_flags %h/%h: got %b want %b", n, d, {dz, ov}, {edz, eov}); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q0, q1, eq;
        logic [7:0]  r0, er;
        logic        dz, ov, edz, eov;
        int          lat;
        run_op(0, 16'd5, 8'h00, 1'b0, q0, r0, dz, ov, lat);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 16'd999, 8'd3);
            @(posedge clk); #1;
            n_checks++; if (bus_e.out_valid !== 1'b1 || bus_e.quotient !== 16'h7FFF) begin n_fail++; $display("[TB] FAIL hold%0d_output: got v=%b q=%h want v=1 q=7fff", i, bus_e.out_valid, bus_e.quotient); end
            n_checks++; if (bus_e.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold%0d_in_ready: got %b want 0", i, bus_e.in_ready); end
        end
        drive(0, 1'b0, 16'd0, 8'd0);
        set_out_ready(0, 1'b1);
        @(posedge clk); #1;
        set_out_ready(0, 1'b0);
        n_checks++; if (bus_e.out_valid !== 1'b0 || bus_e.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL handshake_release: got v=%b rdy=%b want v=0 rdy=1", bus_e.out_valid, bus_e.in_ready); end
        drive(0, 1'b1, 16'hF448, 8'hF7);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 8'h0);
        n_checks++; if (bus_e.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_accept: in_ready got %b want 0", bus_e.in_ready); end
        lat = 0;
        while (!bus_e.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        model(0, 16'hF448, 8'hF7, eq, er, edz, eov);
        q1 = bus_e.quotient;
        n_checks++; if (lat != 18) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d want 18", lat); end
        n_checks++; if (q1 !== eq || bus_e.remainder !== er) begin n_fail++; $display("[TB] FAIL b2b_result: got q=%h r=%h want q=%h r=%h", q1, bus_e.remainder, eq, er); end
        n_checks++; if (bus_e.div_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_flag_clear: div_zero got %b want 0", bus_e.div_zero); end
        set_out_ready(0, 1'b1);
        @(posedge clk); #1;
        set_out_ready(0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] q, eq;
        logic [7:0]  r, er;
        logic        dz, ov, edz, eov;
        int          lat;
        drive(0, 1'b1, 16'd30000, 8'd77);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'd0, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus_e.out_valid !== 1'b0 || bus_e.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reset: got v=%b rdy=%b want v=0 rdy=1", bus_e.out_valid, bus_e.in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        model(0, 16'hCFC7, 8'd99, eq, er, edz, eov);
        run_op(0, 16'hCFC7, 8'd99, 1'b1, q, r, dz, ov, lat);
        n_checks++; if (q !== eq || r !== er) begin n_fail++; $display("[TB] FAIL after_reset_result: got q=%h r=%h want q=%h r=%h", q, r, eq, er); end
    endtask

    task automatic test_approx();
        logic [15:0] n, q, eq;
        logic [7:0]  d, r, er;
        logic        dz, ov, edz, eov;
        int          lat, qa, qe;
        run_op(1, 16'd1000, 8'd3, 1'b1, q, r, dz, ov, lat);
        n_checks++; if (q !== 16'h0140 || r !== 8'h00) begin n_fail++; $display("[TB] FAIL approx_1000_3: got q=%h r=%h want q=0140 r=00", q, r); end
        n_checks++; if (lat != 14) begin n_fail++; $display("[TB] FAIL approx_latency: got %0d want 14", lat); end
        for (int i = 0; i < 30; i++) begin
            n = 16'($urandom);
            d = 8'($urandom);
            if (d == 8'h00) d = 8'h01;
            model(4, n, d, eq, er, edz, eov);
            run_op(1, n, d, 1'b1, q, r, dz, ov, lat);
            n_checks++; if (q !== eq || r !== 8'h00) begin n_fail++; $display("[TB] FAIL approx_rand %h/%h: got q=%h r=%h want q=%h r=00", n, d, q, r, eq); end
            if (!edz && !eov) begin
                qa = $signed(q);
                qe = $signed(n) / $signed(d);
                n_checks++;
                if ((qe - qa) >= 16 || (qa - qe) >= 16 || (qa != 0 && ((qa < 0) != (qe < 0)))) begin
                    n_fail++;
                    $display("[TB] FAIL approx_bound %h/%h: got q=%0d exact=%0d", n, d, qa, qe);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random_exact();
        test_back_to_back();
        test_reset_mid();
        test_approx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
